// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one 1-cycle-latency instruction memory port between fetch and loader
// Ports: i_clk/i_reset (sync, active-low); i_flush kills fetch reads;
// fetch: i_fetch_req/i_fetch_addr -> o_fetch_gnt/o_fetch_stall, o_fetch_rvalid/o_fetch_rdata;
// loader: i_ldr_req/i_ldr_we/i_ldr_addr/i_ldr_wdata -> o_ldr_gnt, o_ldr_rvalid/o_ldr_rdata;
// memory: o_mem_addr/o_mem_we/o_mem_wdata out, i_mem_rdata in (one cycle after address).
module imem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_LDR_BURST = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_fetch_req,
    input  logic [ADDR_W-1:0] i_fetch_addr,
    output logic              o_fetch_gnt,
    output logic              o_fetch_stall,
    output logic              o_fetch_rvalid,
    output logic [DATA_W-1:0] o_fetch_rdata,
    input  logic              i_ldr_req,
    input  logic              i_ldr_we,
    input  logic [ADDR_W-1:0] i_ldr_addr,
    input  logic [DATA_W-1:0] i_ldr_wdata,
    output logic              o_ldr_gnt,
    output logic              o_ldr_rvalid,
    output logic [DATA_W-1:0] o_ldr_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);
    localparam int CW = $clog2(MAX_LDR_BURST + 1);
    typedef enum logic [1:0] {S_IDLE, S_FRD, S_LRD, S_DROP} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] burst_cnt, burst_nxt;
    logic force_f;
    // fetch wins one slot once the loader has held the port for a full burst under contention
    assign force_f        = i_fetch_req && burst_cnt == CW'(MAX_LDR_BURST);
    assign o_ldr_gnt      = i_reset && i_ldr_req && !force_f;
    assign o_fetch_gnt    = i_reset && i_fetch_req && !o_ldr_gnt;
    assign o_fetch_stall  = i_reset && i_fetch_req && !o_fetch_gnt;
    assign o_mem_addr     = o_ldr_gnt ? i_ldr_addr : i_fetch_addr;
    assign o_mem_we       = o_ldr_gnt && i_ldr_we;
    assign o_mem_wdata    = i_ldr_wdata;
    // reset gating hides a read still registered in state during the reset cycle
    assign o_fetch_rvalid = i_reset && state == S_FRD && !i_flush;
    assign o_ldr_rvalid   = i_reset && state == S_LRD;
    assign o_fetch_rdata  = o_fetch_rvalid ? i_mem_rdata : '0;
    assign o_ldr_rdata    = o_ldr_rvalid ? i_mem_rdata : '0;
    always_comb begin
        state_nxt = S_IDLE;
        burst_nxt = '0;
        state_nxt = (o_fetch_gnt && i_flush) ? S_DROP :
                    o_fetch_gnt              ? S_FRD  :
                    (o_ldr_gnt && !i_ldr_we) ? S_LRD  : S_IDLE;
        burst_nxt = (o_fetch_gnt || !i_fetch_req)  ? '0 :
                    (o_ldr_gnt && !force_f && burst_cnt != CW'(MAX_LDR_BURST)) ? burst_cnt + CW'(1) :
                    burst_cnt;
    end
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state     <= S_IDLE;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
        end
    end
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: scoreboard bench for imem_port_arbiter with a memory model and reference model
module tb_imem_port_arbiter;
    localparam int MAXB = 4;
    typedef struct {
        int          cyc;
        logic [31:0] d;
    } exp_t;
    logic        clk = 0;
    logic        rst = 0;
    logic        flush = 0;
    logic        fetch_req = 0;
    logic [31:0] fetch_addr = 0;
    logic        fetch_gnt, fetch_stall, fetch_rvalid;
    logic [31:0] fetch_rdata;
    logic        ldr_req = 0, ldr_we = 0;
    logic [31:0] ldr_addr = 0, ldr_wdata = 0;
    logic        ldr_gnt, ldr_rvalid;
    logic [31:0] ldr_rdata;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata = 0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t fq[$];
    exp_t lq[$];
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic        m_we = 0;
    logic [31:0] m_addr = 0, m_wdata = 0;
    logic        prev_f = 0, prev_fl = 0, prev_l = 0;
    logic [31:0] prev_fd = 0, prev_ld = 0;
    int          streak = 0;

    imem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LDR_BURST(MAXB)) dut (
        .i_clk(clk), .i_reset(rst), .i_flush(flush),
        .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr),
        .o_fetch_gnt(fetch_gnt), .o_fetch_stall(fetch_stall),
        .o_fetch_rvalid(fetch_rvalid), .o_fetch_rdata(fetch_rdata),
        .i_ldr_req(ldr_req), .i_ldr_we(ldr_we), .i_ldr_addr(ldr_addr), .i_ldr_wdata(ldr_wdata),
        .o_ldr_gnt(ldr_gnt), .o_ldr_rvalid(ldr_rvalid), .o_ldr_rdata(ldr_rdata),
        .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // one clock of stimulus; memory environment, reference model and grant checks live here
    task automatic step(input logic fr, input logic [31:0] fa, input logic lr, input logic lwe,
                        input logic [31:0] la, input logic [31:0] lwd, input logic fl, input logic rs);
        logic        eg_l, eg_f;
        logic [31:0] rd;
        @(posedge clk);
        rd = mem[m_addr[7:2]];
        if (m_we) mem[m_addr[7:2]] = m_wdata;
        mem_rdata = rd;
        cyc++;
        #1;
        fetch_req = fr; fetch_addr = fa; ldr_req = lr; ldr_we = lwe;
        ldr_addr = la; ldr_wdata = lwd; flush = fl; rst = rs;
        if (prev_f && !prev_fl && !fl && rs) fq.push_back('{cyc, prev_fd});
        if (prev_l && rs) lq.push_back('{cyc, prev_ld});
        eg_l = rs && lr && !(fr && streak >= MAXB);
        eg_f = rs && fr && !eg_l;
        #1;
        chk("ldr_gnt", 32'(ldr_gnt), 32'(eg_l));
        chk("fetch_gnt", 32'(fetch_gnt), 32'(eg_f));
        chk("fetch_stall", 32'(fetch_stall), 32'(rs && fr && !eg_f));
        chk("mem_we", 32'(mem_we), 32'(eg_l && lwe));
        chk("mem_addr", mem_addr, eg_l ? la : fa);
        if (eg_l && lwe) chk("mem_wdata", mem_wdata, lwd);
        m_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata;
        prev_fd = ref_mem[fa[7:2]];
        prev_ld = ref_mem[la[7:2]];
        if (eg_l && lwe) ref_mem[la[7:2]] = lwd;
        prev_f  = eg_f;
        prev_fl = fl;
        prev_l  = eg_l && !lwe;
        streak  = (!rs || !fr || !eg_l) ? 0 : streak + 1;
    endtask

    task automatic idle(input logic rs);
        step(0, 0, 0, 0, 0, 0, 0, rs);
    endtask

    // monitor: whenever a response is due or shown, match it against the scoreboard
    initial forever begin
        exp_t e;
        logic ev;
        @(negedge clk);
        ev = fq.size() != 0 && fq[0].cyc == cyc;
        e = '{0, 0};
        if (ev) e = fq.pop_front();
        chk("fetch_rvalid", 32'(fetch_rvalid), 32'(ev));
        chk("fetch_rdata", fetch_rdata, ev ? e.d : 32'h0);
        ev = lq.size() != 0 && lq[0].cyc == cyc;
        e = '{0, 0};
        if (ev) e = lq.pop_front();
        chk("ldr_rvalid", 32'(ldr_rvalid), 32'(ev));
        chk("ldr_rdata", ldr_rdata, ev ? e.d : 32'h0);
    end

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            mem[i] = v;
            ref_mem[i] = v;
        end
        idle(0);
        idle(0);
        idle(1);
        step(1, 32'h0, 0, 0, 0, 0, 0, 1);
        step(1, 32'h4, 0, 0, 0, 0, 0, 1);
        step(1, 32'h8, 0, 0, 0, 0, 0, 1);
        idle(1);
        for (int i = 0; i < 15; i++) step(1, 32'h20, 1, 0, 32'(i * 4), 0, 0, 1);
        idle(1);
        step(0, 0, 1, 1, 32'h40, 32'hDEADBEEF, 0, 1);
        step(1, 32'h40, 0, 0, 0, 0, 0, 1);
        idle(1);
        step(1, 32'hC, 0, 0, 0, 0, 1, 1);
        idle(1);
        step(1, 32'hC, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 1, 0, 32'h10, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        step(1, 32'h14, 0, 0, 0, 0, 0, 1);
        step(1, 32'h18, 1, 0, 32'h1C, 0, 0, 0);
        step(1, 32'h18, 0, 0, 0, 0, 0, 1);
        idle(1);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, {24'h0, 6'($urandom), 2'b00},
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                 {24'h0, 6'($urandom), 2'b00}, $urandom,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 63) != 0);
        idle(1);
        idle(1);
        @(posedge clk);
        #2;
        chk("scoreboard_drain", 32'(fq.size() + lq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
